// File: rtl/sevenseg_scan_driver_if.sv
// Display bus: BCD time and indicator inputs plus the registered drive outputs.
// The master side feeds time/indicator bytes and watches the display pins.
interface sevenseg_scan_driver_if;
  logic [7:0] secs;
  logic [7:0] mins;
  logic       leda;
  logic       ledb;
  logic       blank_lz;
  logic       blink;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] led;

  modport master (
    output secs, mins, leda, ledb, blank_lz, blink,
    input  seg, dp, an, led
  );

  modport slave (
    input  secs, mins, leda, ledb, blank_lz, blink,
    output seg, dp, an, led
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with a frame-consistent input
// snapshot, per-slot anode dead time, colon blink and optional display blink.
module sevenseg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 125
) (
  input logic                  clk,
  input logic                  resetn,
  sevenseg_scan_driver_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p;
  logic [1:0]    idx;
  logic [FW-1:0] f;
  logic          phase;
  logic [7:0]    snap_secs;
  logic [7:0]    snap_mins;
  logic [1:0]    snap_led;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [3:0]    an_d;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign slot_end  = (p == P_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  // Slot prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p     <= '0;
      idx   <= '0;
      f     <= '0;
      phase <= 1'b0;
    end else begin
      p <= slot_end ? '0 : p + 1'b1;
      if (slot_end) idx <= idx + 1'b1;  // 3 -> 0 by natural wrap
      if (frame_end) begin
        f <= (f == F_LAST) ? '0 : f + 1'b1;
        if (f == F_LAST) phase <= ~phase;
      end
    end
  end

  // Inputs are captured only at the frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_secs <= '0;
      snap_mins <= '0;
      snap_led  <= '0;
    end else if (frame_end) begin
      snap_secs <= bus.secs;
      snap_mins <= bus.mins;
      snap_led  <= {bus.leda, bus.ledb};
    end
  end

  // Next-cycle display drive from the current scan state.
  always_comb begin
    nib   = snap_secs[3:0];
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = 4'hF;
    case (idx)
      2'd0: nib = snap_secs[3:0];
      2'd1: nib = snap_secs[7:4];
      2'd2: nib = snap_mins[3:0];
      2'd3: nib = snap_mins[7:4];
      default: nib = snap_secs[3:0];
    endcase
    if (idx == 2'd3 && bus.blank_lz && snap_mins[7:4] == 4'd0)
      seg_d = 7'h7F;
    else
      seg_d = decode(nib);
    if (idx == 2'd2 && phase) dp_d = 1'b0;
    // Blink uses the live input; dead time keeps the previous digit from ghosting.
    if (p >= P_DEAD && !(bus.blink && !phase))
      an_d = ~(4'b0001 << idx);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
      bus.an  <= 4'hF;
      bus.led <= 2'b00;
    end else begin
      bus.seg <= seg_d;
      bus.dp  <= dp_d;
      bus.an  <= an_d;
      bus.led <= snap_led;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: a time-based reference model pushes the
// expected outputs of every cycle to a queue; they are popped one cycle later.
module tb_sevenseg_scan_driver;
  localparam int SD = 8;
  localparam int DD = 2;
  localparam int BF = 1;
  localparam int FRAME = 4 * SD;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] led;
  } exp_t;

  logic clk;
  logic resetn;
  sevenseg_scan_driver_if bus();

  sevenseg_scan_driver #(.SCAN_DIV(SD), .DEAD(DD), .BLINK_FRAMES(BF)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  exp_t sb[$];
  logic [7:0] m_secs, m_mins;
  logic [1:0] m_led;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " seg"}, 32'(bus.seg), 32'h7F);
    check({tag, " dp"},  32'(bus.dp),  32'h1);
    check({tag, " an"},  32'(bus.an),  32'hF);
    check({tag, " led"}, 32'(bus.led), 32'h0);
  endtask

  // One clock: model the outputs due from the current state, advance, compare.
  task automatic step();
    exp_t e;
    exp_t o;
    int p, idx, ph;
    logic [3:0] nib;
    p   = t % SD;
    idx = (t / SD) % 4;
    ph  = (t / (FRAME * BF)) % 2;
    case (idx)
      0: nib = m_secs[3:0];
      1: nib = m_secs[7:4];
      2: nib = m_mins[3:0];
      default: nib = m_mins[7:4];
    endcase
    e.seg = (idx == 3 && bus.blank_lz && m_mins[7:4] == 4'd0) ? 7'h7F : ref_dec(nib);
    e.dp  = (idx == 2 && ph == 1) ? 1'b0 : 1'b1;
    e.an  = (p < DD || (bus.blink && ph == 0)) ? 4'hF : ~(4'b0001 << idx);
    e.led = m_led;
    sb.push_back(e);
    if (t % FRAME == FRAME - 1) begin
      m_secs = bus.secs;
      m_mins = bus.mins;
      m_led  = {bus.leda, bus.ledb};
    end
    @(posedge clk);
    #1;
    t++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue required one entry");
    end else begin
      o = sb.pop_front();
      check($sformatf("seg t=%0d", t), 32'(bus.seg), 32'(o.seg));
      check($sformatf("dp t=%0d", t),  32'(bus.dp),  32'(o.dp));
      check($sformatf("an t=%0d", t),  32'(bus.an),  32'(o.an));
      check($sformatf("led t=%0d", t), 32'(bus.led), 32'(o.led));
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_secs = '0;
    m_mins = '0;
    m_led  = '0;
    sb.delete();
  endtask

  initial begin
    resetn       = 1'b0;
    bus.secs     = 8'h59;
    bus.mins     = 8'h12;
    bus.leda     = 1'b1;
    bus.ledb     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink    = 1'b0;
    model_reset();

    // Reset state held while resetn is low.
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");

    // Release: first frame shows snapshot 0, then 59/12 from cycle 33.
    #1 resetn = 1'b1;
    repeat (80) step();

    // Tear-free snapshot: load 09, then change to 10 while digit 1 is scanned.
    bus.secs = 8'h09;
    bus.leda = 1'b0;
    bus.ledb = 1'b1;
    while (t % FRAME != 0) step();
    repeat (FRAME) step();
    while (t % FRAME != 10) step();
    bus.secs = 8'h10;
    repeat (70) step();

    // Decode edges: dash for non-BCD nibble, leading-zero blank on and off.
    bus.mins     = 8'h0A;
    bus.blank_lz = 1'b1;
    repeat (70) step();
    bus.blank_lz = 1'b0;
    repeat (40) step();
    bus.secs = 8'hC7;
    bus.mins = 8'h30;
    bus.blank_lz = 1'b1;
    repeat (70) step();

    // Whole-display blink during phase 0.
    bus.blink = 1'b1;
    repeat (100) step();
    bus.blink = 1'b0;
    repeat (20) step();

    // Mid-scan reset at idx 2, p 5.
    bus.secs = 8'h47;
    bus.mins = 8'h05;
    while (t % FRAME != 2 * SD + 5) step();
    resetn = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset("midrst hold");
    model_reset();
    resetn = 1'b1;
    repeat (80) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
